// File: rtl/vram_pkg.sv
// vram_pkg: shared constants, size codes and FSM state encoding
// for the VRAM port A CPU access adapter.
package vram_pkg;

  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    WR   = ST_WR,
    ACK  = ST_ACK
  } state_e;

  // size code 3 behaves as a word
  function automatic logic is_word(
    input logic [1:0] sz
  );
    return sz >= SZ_WORD;
  endfunction

endpackage

// File: rtl/vram_cpu_rmw_if.sv
// vram_cpu_rmw_if: CPU-side request/ack bus of the VRAM A adapter.
// master = CPU bus decoder, slave = vram_cpu_rmw.
interface vram_cpu_rmw_if;
  import vram_pkg::*;

  logic               cpu_req;
  logic               cpu_we;
  logic [1:0]         cpu_size;
  logic [15:0]        cpu_addr;
  logic [VRAM_DW-1:0] cpu_wdata;
  logic [VRAM_DW-1:0] cpu_rdata;
  logic               cpu_ack;
  logic               busy;

  modport master (
    output cpu_req, cpu_we, cpu_size,
    output cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_size,
    input  cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, busy
  );

endinterface

// File: rtl/vram_lane_merge.sv
// vram_lane_merge: folds lane-aligned write data into an old word.
// VRAM_BYTE_DUP_EN: byte writes fill both lanes of their halfword.
module vram_lane_merge
  import vram_pkg::*;
(
  input  logic [VRAM_DW-1:0] old_word,
  input  logic [VRAM_DW-1:0] wdata,
  input  logic [1:0]         size,
  input  logic [1:0]         lane,
  output logic [VRAM_DW-1:0] merged
);

  logic [3:0]         be;
  logic [VRAM_DW-1:0] wd;
  logic [7:0]         bsel;

  assign bsel = wdata[{lane, 3'b000} +: 8];

  always_comb begin
    be = 4'b1111;
    wd = wdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
`ifdef VRAM_BYTE_DUP_EN
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {4{bsel}};
`else
        be = 4'b0001 << lane;
        wd = {4{bsel}};
`endif
      end
      size == SZ_HALF: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        be = 4'b1111;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i])
        merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

endmodule

// File: rtl/vram_cpu_rmw.sv
// vram_cpu_rmw: CPU byte/half/word access adapter for VRAM port A.
// Build option VRAM_BYTE_DUP_EN (in vram_lane_merge) duplicates bytes.
module vram_cpu_rmw
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  vram_cpu_rmw_if.slave      cpu,
  input  logic               ppu_hold,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [VRAM_DW-1:0] vram_dout,
  output logic               vram_we,
  output logic [VRAM_DW-1:0] vram_din
);

  state_e             state;
  logic               we_q;
  logic [1:0]         size_q;
  logic [15:0]        addr_q;
  logic [VRAM_DW-1:0] wdata_q;
  logic [VRAM_DW-1:0] data_q;
  logic [VRAM_DW-1:0] rdata_q;
  logic [VRAM_DW-1:0] merged;

  vram_lane_merge u_merge (
    .old_word (data_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .merged   (merged)
  );

  assign vram_addr     = addr_q[15:2];
  assign vram_din      = merged;
  // the PPU fetcher owns the port whenever it holds
  assign vram_we       = (state == WR) && !ppu_hold;
  assign cpu.cpu_ack   = (state == ACK);
  assign cpu.busy      = (state != IDLE);
  assign cpu.cpu_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu.cpu_req && !ppu_hold) begin
            we_q    <= cpu.cpu_we;
            size_q  <= cpu.cpu_size;
            addr_q  <= cpu.cpu_addr;
            wdata_q <= cpu.cpu_wdata;
            if (cpu.cpu_we && is_word(cpu.cpu_size))
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          if (!ppu_hold) begin
            data_q <= vram_dout;
            if (!we_q)
              rdata_q <= vram_dout;
            state <= we_q ? WR : ACK;
          end
        end
        WR: begin
          if (!ppu_hold)
            state <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_cpu_rmw.sv
// tb_vram_cpu_rmw: randomized and directed checks of vram_cpu_rmw
// against a word-array reference model of VRAM A.
module tb_vram_cpu_rmw;

  logic        clk;
  logic        rst;
  logic        ppu_hold;
  logic [13:0] vram_addr;
  logic [31:0] vram_dout;
  logic        vram_we;
  logic [31:0] vram_din;

  int nvec;
  int nerr;

  bit [31:0] mem   [16384];
  bit [31:0] model [16384];

  vram_cpu_rmw_if bus ();

  vram_cpu_rmw dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (bus),
    .ppu_hold  (ppu_hold),
    .vram_addr (vram_addr),
    .vram_dout (vram_dout),
    .vram_we   (vram_we),
    .vram_din  (vram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vram_dout = mem[vram_addr];

  always @(posedge clk)
    if (vram_we)
      mem[vram_addr] <= vram_din;

  function automatic bit [31:0] ref_merge(
    input bit [31:0] old,
    input bit [31:0] wd,
    input bit [1:0]  sz,
    input bit [15:0] a
  );
    bit [31:0] r;
    int b;
    int h;
    r = old;
    b = int'(a[1:0]);
    h = a[1] ? 2 : 0;
    if (sz >= 2'd2) begin
      r = wd;
    end else if (sz == 2'd1) begin
      r[8*h +: 16] = wd[8*h +: 16];
    end else begin
`ifdef VRAM_BYTE_DUP_EN
      r[8*h +: 8]     = wd[8*b +: 8];
      r[8*h + 8 +: 8] = wd[8*b +: 8];
`else
      r[8*b +: 8] = wd[8*b +: 8];
`endif
    end
    return r;
  endfunction

  task automatic access(
    input  bit        we,
    input  bit [1:0]  sz,
    input  bit [15:0] a,
    input  bit [31:0] wd,
    input  bit [15:0] hm,
    output bit [31:0] rd,
    output bit [31:0] din,
    output int        lat
  );
    int        widx;
    int        need;
    int        good;
    int        expk;
    int        nwe;
    bit        done;
    bit [31:0] exp_din;
    widx    = int'(a[15:2]);
    exp_din = ref_merge(model[widx], wd, sz, a);
    need    = (we && sz < 2'd2) ? 2 : 1;
    good    = 0;
    expk    = -1;
    nwe     = 0;
    done    = 1'b0;
    rd      = '0;
    din     = '0;
    lat     = -1;
    @(negedge clk);
    ppu_hold      = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_size  = sz;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'($urandom);
    bus.cpu_size  = 2'($urandom);
    bus.cpu_addr  = 16'($urandom);
    bus.cpu_wdata = $urandom;
    for (int k = 1; k <= 40 && !done; k++) begin
      ppu_hold = (k <= 16) ? hm[k-1] : 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.busy !== 1'b1) begin
        nerr++;
        $display("FAIL busy cyc%0d: got %b want 1", k, bus.busy);
      end
      if (vram_we === 1'b1) begin
        nwe++;
        din = vram_din;
        nvec++;
        if (ppu_hold !== 1'b0 || !we) begin
          nerr++;
          $display("FAIL we_illegal cyc%0d: hold=%b we_req=%b", k, ppu_hold, we);
        end
        nvec++;
        if (vram_addr !== a[15:2]) begin
          nerr++;
          $display("FAIL waddr: got %h want %h", vram_addr, a[15:2]);
        end
        nvec++;
        if (vram_din !== exp_din) begin
          nerr++;
          $display("FAIL wdin: got %h want %h", vram_din, exp_din);
        end
      end
      if (expk < 0 && !ppu_hold) begin
        good++;
        if (good == need)
          expk = k + 1;
      end
      nvec++;
      if (bus.cpu_ack !== (k == expk)) begin
        nerr++;
        $display("FAIL ack cyc%0d: got %b want %b", k, bus.cpu_ack, k == expk);
      end
      if (bus.cpu_ack === 1'b1 || k == expk) begin
        done = 1'b1;
        lat  = (bus.cpu_ack === 1'b1) ? k : -1;
        rd   = bus.cpu_rdata;
        if (!we) begin
          nvec++;
          if (bus.cpu_rdata !== model[widx]) begin
            nerr++;
            $display("FAIL rdata @%h: got %h want %h", a, bus.cpu_rdata, model[widx]);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    ppu_hold = 1'b0;
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL ack_timeout @%h: no ack in 40 cycles", a);
    end
    nvec++;
    if (nwe != (we ? 1 : 0)) begin
      nerr++;
      $display("FAIL we_count @%h: got %0d want %0d", a, nwe, we ? 1 : 0);
    end
    if (we)
      model[widx] = exp_din;
    nvec++;
    if (mem[widx] !== model[widx]) begin
      nerr++;
      $display("FAIL mem @%h: got %h want %h", widx, mem[widx], model[widx]);
    end
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    ppu_hold      = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_size  = 2'd0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({bus.cpu_ack, bus.busy, vram_we} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_ctl: got %b want 000", {bus.cpu_ack, bus.busy, vram_we});
    end
    nvec++;
    if (bus.cpu_rdata !== 32'h0 || vram_din !== 32'h0 || vram_addr !== 14'h0) begin
      nerr++;
      $display("FAIL reset_data: rdata %h din %h addr %h want 0", bus.cpu_rdata, vram_din, vram_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    bit [31:0] rd;
    bit [31:0] din;
    int        lat;
    access(1'b1, 2'd2, 16'h0104, 32'hDEADBEEF, 16'h0, rd, din, lat);
    nvec++;
    if (din !== 32'hDEADBEEF || lat != 2) begin
      nerr++;
      $display("FAIL word_wr: din %h lat %0d want DEADBEEF 2", din, lat);
    end
    access(1'b0, 2'd2, 16'h0104, 32'h0, 16'h0, rd, din, lat);
    nvec++;
    if (rd !== 32'hDEADBEEF || lat != 2) begin
      nerr++;
      $display("FAIL word_rd: rdata %h lat %0d want DEADBEEF 2", rd, lat);
    end
  endtask

  task automatic test_subword;
    bit [31:0] rd;
    bit [31:0] din;
    bit [31:0] want;
    int        lat;
    access(1'b1, 2'd1, 16'h0106, 32'h12340000, 16'h0, rd, din, lat);
    nvec++;
    if (din !== 32'h1234BEEF || lat != 3) begin
      nerr++;
      $display("FAIL half_wr: din %h lat %0d want 1234BEEF 3", din, lat);
    end
    access(1'b1, 2'd2, 16'h0104, 32'hDEADBEEF, 16'h0, rd, din, lat);
    access(1'b1, 2'd0, 16'h0106, 32'h00AB0000, 16'h0, rd, din, lat);
`ifdef VRAM_BYTE_DUP_EN
    want = 32'hABABBEEF;
`else
    want = 32'hDEABBEEF;
`endif
    nvec++;
    if (din !== want || lat != 3) begin
      nerr++;
      $display("FAIL byte_wr: din %h lat %0d want %h 3", din, lat, want);
    end
    access(1'b1, 2'd2, 16'h0104, 32'hDEADBEEF, 16'h0, rd, din, lat);
  endtask

  task automatic test_hold;
    bit [31:0] rd;
    bit [31:0] din;
    int        lat;
    access(1'b1, 2'd1, 16'h0106, 32'h12340000, 16'h001E, rd, din, lat);
    nvec++;
    if (din !== 32'h1234BEEF || lat != 7) begin
      nerr++;
      $display("FAIL hold_wr: din %h lat %0d want 1234BEEF 7", din, lat);
    end
    access(1'b1, 2'd2, 16'h0104, 32'hDEADBEEF, 16'h0, rd, din, lat);
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_size  = 2'd0;
    bus.cpu_addr  = 16'h0106;
    bus.cpu_wdata = 32'h00AB0000;
    @(posedge clk);
    #2;
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    nvec++;
    if ({bus.cpu_ack, bus.busy, vram_we} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_mid_ctl: got %b want 000", {bus.cpu_ack, bus.busy, vram_we});
    end
    nvec++;
    if (bus.cpu_rdata !== 32'h0 || vram_din !== 32'h0 || vram_addr !== 14'h0) begin
      nerr++;
      $display("FAIL rst_mid_data: rdata %h din %h addr %h want 0", bus.cpu_rdata, vram_din, vram_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nvec++;
      if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0) begin
        nerr++;
        $display("FAIL rst_mid_ack: ack %b busy %b want 0 0", bus.cpu_ack, bus.busy);
      end
    end
    nvec++;
    if (mem[14'h041] !== model[14'h041]) begin
      nerr++;
      $display("FAIL rst_mid_mem: got %h want %h", mem[14'h041], model[14'h041]);
    end
  endtask

  task automatic test_idle_hold;
    @(negedge clk);
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    bus.cpu_addr = 16'h0104;
    ppu_hold    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nvec++;
      if (bus.busy !== 1'b0) begin
        nerr++;
        $display("FAIL idle_hold: busy %b want 0", bus.busy);
      end
    end
    bus.cpu_req = 1'b0;
    ppu_hold    = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit [31:0] rd;
    bit [31:0] din;
    int        lat;
    bit [4:0]  exp_busy;
    bit [4:0]  exp_ack;
    exp_busy = 5'b11011;
    exp_ack  = 5'b10010;
    access(1'b1, 2'd2, 16'h0108, $urandom, 16'h0, rd, din, lat);
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_size = 2'd2;
    bus.cpu_addr = 16'h0104;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      nvec++;
      if (bus.busy !== exp_busy[k-1] || bus.cpu_ack !== exp_ack[k-1]) begin
        nerr++;
        $display("FAIL b2b cyc%0d: busy %b ack %b want %b %b", k, bus.busy, bus.cpu_ack, exp_busy[k-1], exp_ack[k-1]);
      end
      if (k == 2) begin
        nvec++;
        if (bus.cpu_rdata !== model[14'h041]) begin
          nerr++;
          $display("FAIL b2b_rd1: got %h want %h", bus.cpu_rdata, model[14'h041]);
        end
        bus.cpu_addr = 16'h0108;
      end
      if (k == 5) begin
        nvec++;
        if (bus.cpu_rdata !== model[14'h042]) begin
          nerr++;
          $display("FAIL b2b_rd2: got %h want %h", bus.cpu_rdata, model[14'h042]);
        end
        bus.cpu_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    bit [31:0] rd;
    bit [31:0] din;
    bit [15:0] a;
    int        lat;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = 16'($urandom);
      else
        a = 16'h0100 + 16'($urandom_range(0, 63));
      access(1'($urandom), 2'($urandom), a, $urandom,
             16'($urandom & $urandom), rd, din, lat);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_word();
    test_subword();
    test_hold();
    test_rst_mid();
    test_idle_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vram_cpu_rmw.md
# vram_cpu_rmw

CPU-side access adapter for the 16K x 32-bit VRAM A array: accepts byte/halfword/word CPU reads and writes and turns them into whole-word VRAM port cycles. The array write port takes 32-bit words only, so sub-word writes become a read-modify-write sequence. The block sits between the CPU bus decoder and VRAM port A. A hold input from the PPU fetcher stalls it so that pixel fetches keep priority.

## Interface
- No parameters. Widths are fixed by the VRAM A geometry: 14-bit word address, 32-bit data.
- clk  in  1  single clock for the block and for VRAM port A
- rst  in  1  reset, asynchronous and active-high
- cpu_req  in  1  access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_size  in  2  0 byte, 1 halfword, 2 word, 3 treated as word
- cpu_addr  in  16  byte address inside VRAM A; wraps naturally at 64 KB
- cpu_wdata  in  32  write data, lane-aligned (byte n in bits 8n+7:8n)
- cpu_rdata  out  32  full read word, valid while cpu_ack=1 and held afterwards
- cpu_ack  out  1  one-cycle completion pulse
- busy  out  1  high from request acceptance through the ACK cycle
- ppu_hold  in  1  PPU owns the VRAM port this cycle; block must not drive it
- vram_addr  out  14  word address to port A
- vram_dout  in  32  port A read data, combinational from vram_addr
- vram_we  out  1  port A write enable
- vram_din  out  32  port A write data

## Operation
- FSM states: IDLE, RD, WR, ACK.
- IDLE: at a clock edge with cpu_req=1 and ppu_hold=0, latch we/size/addr/wdata and set busy.
  - Read or sub-word write: go to RD.
  - Word write: go to WR.
  - If ppu_hold=1, stay in IDLE.
- RD:
  - Drive vram_addr = addr[15:2].
  - At the edge with ppu_hold=0, capture vram_dout into the data register.
  - Read: go to ACK. Sub-word write: go to WR.
  - If ppu_hold=1, stay in RD with no capture.
- WR:
  - Drive vram_addr, vram_din = merged word, vram_we=1, but only while ppu_hold=0.
  - With ppu_hold=1: vram_we=0 and stay in WR.
  - On a write edge, go to ACK.
- ACK: cpu_ack=1 for exactly one cycle, busy=1, then go to IDLE. A new request is accepted in IDLE no earlier than the cycle after ACK.
- Lane merge:
  - Word: all four lanes from wdata.
  - Halfword: lanes {1,0} if addr[1]=0, else {3,2}; addr[0] ignored.
  - Byte: lane addr[1:0] only, unless the quirk is enabled (see Configuration).
  - Lanes not written keep the captured RD value.
- Word accesses ignore addr[1:0].
- cpu_rdata is the raw 32-bit word; the CPU side does lane rotation.
- Dropping cpu_req mid-operation does not abort the access; it completes and acks.
- cpu_wdata/cpu_addr changes after acceptance are ignored because the values are latched.

## Timing
- Reset values: state IDLE; cpu_ack 0, busy 0, cpu_rdata 0, vram_we 0, vram_addr 0, vram_din 0. Reset asserted mid-operation aborts immediately: any pending write is dropped and no ack is issued.
- Latency from the accepting edge to the cpu_ack cycle, with no hold:
  - read: 2 cycles
  - word write: 2 cycles
  - byte/halfword write: 3 cycles
- Each ppu_hold cycle spent in RD or WR adds one cycle. vram_we is never high while ppu_hold=1.
- vram_we is high for exactly one cycle per write access.
- cpu_ack is registered, with no combinational path from cpu_req or ppu_hold.

## Configuration
- VRAM_BYTE_DUP_EN defined: GBA byte-write behaviour. The byte write data (wdata lane addr[1:0]) is written to both lanes of the addressed halfword, i.e. lanes {1,0} or {3,2}.
- VRAM_BYTE_DUP_EN undefined: plain byte write; only lane addr[1:0] changes.

## Structure
- vram_pkg holds:
  - the size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD
  - the FSM state enum
  - the VRAM_AW=14 and VRAM_DW=32 constants
- One sub-module, vram_lane_merge: combinational. It takes old word, wdata, size and addr[1:0] and returns the merged word. The VRAM_BYTE_DUP_EN switch lives only here.

## Test plan
- Word write 0xDEADBEEF at addr 0x0104, no hold:
  - vram_we pulses at word 0x0041 with din 0xDEADBEEF.
  - ack follows 2 cycles after acceptance.
  - A read of 0x0104 then returns 0xDEADBEEF with 2-cycle latency.
- Halfword write 0x1234 (wdata 0x12340000) at addr 0x0106 over old 0xDEADBEEF: din 0x1234BEEF, ack at 3 cycles.
- Byte write 0xAB (wdata 0x00AB0000) at addr 0x0106 over 0xDEADBEEF:
  - macro defined: din 0xABABBEEF
  - macro undefined: din 0xDEABBEEF
- ppu_hold high for 4 cycles starting in WR of a halfword write: vram_we stays 0 throughout, write lands after hold drops, ack at 7 cycles.
- rst asserted during RD of a byte write: outputs return to reset values at once, memory is unchanged, no ack.
- Back-to-back requests with cpu_req held high: second access accepted on the edge after ACK; busy stays 0 for exactly that one IDLE cycle.
